// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
//   Shared definitions for the UART blocks: the auto-baud detector FSM state
//   encoding and the generator-related constants (16x oversampling, divisor
//   fraction in eighths, 13-bit integer divisor).
// ---------------------------------------------------------------------------
package uart_pkg;

  // Falling edges produced by a 0x55 sync character (bit times 0,2,4,6,8).
  localparam int unsigned SYNC_EDGES       = 5;
  // The generator ticks 16 times per bit.
  localparam int unsigned OVERSAMPLE_SHIFT = 4;
  // Fractional divisor resolution: eighths of a clock.
  localparam int unsigned FRAC_BITS        = 3;
  localparam int unsigned BAUD_VAL_W       = 13;
  localparam int unsigned BAUD_VAL_MAX     = (1 << BAUD_VAL_W) - 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_HUNT,
    ST_MEAS,
    ST_CALC,
    ST_DONE,
    ST_ERR
  } state_e;

endpackage : uart_pkg

// File: rtl/uart_rx_sync.sv
// ---------------------------------------------------------------------------
// uart_rx_sync
//   Two-flop synchronizer for the asynchronous RX pin plus falling-edge
//   detection. Shared by the auto-baud detector and the receiver.
//
//   i_clk      system clock
//   i_reset    synchronous, active-high reset
//   i_rx       asynchronous serial input, idle high
//   o_rx_sync  synchronized RX level
//   o_fall     one-cycle pulse on a high-to-low transition of RX
// ---------------------------------------------------------------------------
module uart_rx_sync (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_rx,
  output logic o_rx_sync,
  output logic o_fall
);

  // r_sync[0] is the newest sample, r_sync[1] the older one.
  logic [1:0] r_sync;

  // Reset to the idle (high) level so leaving reset never fakes an edge.
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    if (i_reset) r_sync <= 2'b11;
    else         r_sync <= {r_sync[0], i_rx};
  end

  assign o_rx_sync = r_sync[1];
  assign o_fall    = r_sync[1] & ~r_sync[0];

endmodule : uart_rx_sync

// File: rtl/uart_autobaud_detect.sv
// ---------------------------------------------------------------------------
// uart_autobaud_detect
//   Measures a received 0x55 sync character and returns the baud generator
//   divisor (integer part + eighths) that reproduces the measured bit rate.
//   The span from the 1st to the 5th falling edge is 8 bit times; each
//   2-bit interval must match the first one within I0>>TOL_SHIFT.
//
//   i_clk               system clock
//   i_reset             synchronous, active-high reset
//   i_start             1-cycle pulse: arm a measurement (IDLE/DONE only)
//   i_rx                asynchronous serial input, idle high
//   o_busy              measurement in progress
//   o_locked            o_baud_val/o_baud_val_fraction hold a valid result
//   o_det_err           1-cycle pulse: measurement rejected
//   o_baud_val          integer divisor
//   o_baud_val_fraction fractional divisor, eighths
// ---------------------------------------------------------------------------
module uart_autobaud_detect
  import uart_pkg::*;
#(
  parameter int unsigned TOL_SHIFT = 3,
  parameter int unsigned CNT_W     = 21
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic                  i_rx,
  output logic                  o_busy,
  output logic                  o_locked,
  output logic                  o_det_err,
  output logic [BAUD_VAL_W-1:0] o_baud_val,
  output logic [FRAC_BITS-1:0]  o_baud_val_fraction
);

  // Divisor arithmetic width: one bit above the counter so C+8 cannot wrap,
  // and at least wide enough to hold the sign plus E[15:3].
  localparam int unsigned E_W =
    (CNT_W + 1 > BAUD_VAL_W + FRAC_BITS + 1) ? CNT_W + 1 : BAUD_VAL_W + FRAC_BITS + 1;
  localparam int unsigned ROUND_ADD  = 1 << (OVERSAMPLE_SHIFT - 1);
  // The generator divides by (BAUD_VAL+1), so remove one whole clock (8/8).
  localparam int unsigned DIV_OFFSET = 1 << FRAC_BITS;

  state_e                r_state, w_next_state;
  logic [CNT_W-1:0]      r_c;          // total clocks since edge 1
  logic [CNT_W-1:0]      r_i;          // clocks since the latest edge, minus one
  logic [CNT_W-1:0]      r_i0;         // reference 2-bit interval
  logic [2:0]            r_edge_cnt;   // falling edges seen so far
  logic [BAUD_VAL_W-1:0] r_baud_val;
  logic [FRAC_BITS-1:0]  r_baud_frac;

  logic                  w_rx_sync, w_fall;
  logic [CNT_W-1:0]      w_interval, w_diff, w_tol;
  logic                  w_out_of_tol, w_c_full;
  logic [E_W-1:0]        w_round;
  logic signed [E_W-1:0] w_e, w_e_int;
  logic                  w_calc_bad;

  uart_rx_sync u_rx_sync (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_rx     (i_rx),
    .o_rx_sync(w_rx_sync),
    .o_fall   (w_fall)
  );

  // I is cleared on the edge cycle itself, so the interval that ends on
  // the current edge is I+1.
  always_comb begin
    w_interval   = r_i + CNT_W'(1);
    w_diff       = (w_interval > r_i0) ? (w_interval - r_i0) : (r_i0 - w_interval);
    w_tol        = r_i0 >> TOL_SHIFT;
    w_out_of_tol = (w_diff > w_tol);
    w_c_full     = (r_c == '1);
  end

  // E = round(C/16) - 8 = 8*BAUD_VAL + FRACTION.
  always_comb begin
    w_round    = ({{(E_W - CNT_W){1'b0}}, r_c} + E_W'(ROUND_ADD)) >> OVERSAMPLE_SHIFT;
    w_e        = $signed(w_round) - $signed(E_W'(DIV_OFFSET));
    w_e_int    = w_e >>> FRAC_BITS;
    w_calc_bad = w_e[E_W-1] || (w_e_int > $signed(E_W'(BAUD_VAL_MAX)));
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= ST_IDLE;
    else         r_state <= w_next_state;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default assignment first so no path through the case leaves the
    // signal unassigned, which would infer a latch.
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (i_start)   w_next_state = ST_ARM;
      ST_ARM:  if (w_rx_sync) w_next_state = ST_HUNT;
      ST_HUNT: if (w_fall)    w_next_state = ST_MEAS;
      ST_MEAS: begin
        if (w_c_full) begin
          w_next_state = ST_ERR;
        end else if (w_fall) begin
          // Edge 2 only defines the reference interval; later edges compare.
          if (r_edge_cnt != 3'd1 && w_out_of_tol)
            w_next_state = ST_ERR;
          else if (r_edge_cnt == 3'(SYNC_EDGES - 1))
            w_next_state = ST_CALC;
        end
      end
      ST_CALC: w_next_state = w_calc_bad ? ST_ERR : ST_DONE;
      // A START here re-arms; an edge in the same cycle is simply not looked at.
      ST_DONE: if (i_start)   w_next_state = ST_ARM;
      ST_ERR:  w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Output decode.
  always_comb begin
    o_busy    = 1'b0;
    o_locked  = 1'b0;
    o_det_err = 1'b0;
    case (r_state)
      ST_ARM, ST_HUNT, ST_MEAS, ST_CALC: o_busy    = 1'b1;
      ST_DONE:                           o_locked  = 1'b1;
      ST_ERR:                            o_det_err = 1'b1;
      default: ;
    endcase
  end

  // Counters and result registers. The divisor outputs only move on a
  // successful CALC so a live generator never sees a partial value.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_c         <= '0;
      r_i         <= '0;
      r_i0        <= '0;
      r_edge_cnt  <= '0;
      r_baud_val  <= '0;
      r_baud_frac <= '0;
    end else begin
      case (r_state)
        ST_HUNT: begin
          if (w_fall) begin
            r_c        <= '0;
            r_i        <= '0;
            r_edge_cnt <= 3'd1;
          end
        end
        ST_MEAS: begin
          if (!w_c_full) r_c <= r_c + CNT_W'(1);
          if (w_fall) begin
            if (r_edge_cnt == 3'd1) r_i0 <= w_interval;
            r_i        <= '0;
            r_edge_cnt <= r_edge_cnt + 3'd1;
          end else begin
            r_i <= r_i + CNT_W'(1);
          end
        end
        ST_CALC: begin
          if (!w_calc_bad) begin
            r_baud_val  <= w_e[FRAC_BITS +: BAUD_VAL_W];
            r_baud_frac <= w_e[FRAC_BITS-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign o_baud_val          = r_baud_val;
  assign o_baud_val_fraction = r_baud_frac;

endmodule : uart_autobaud_detect

// File: tb/tb_uart_autobaud_detect.sv
// ---------------------------------------------------------------------------
// tb_uart_autobaud_detect
//   Drives sync characters on RX at known bit periods and compares the
//   recovered divisor against values pushed to a scoreboard queue when the
//   stimulus is issued. A narrow counter keeps the timeout case short.
// ---------------------------------------------------------------------------
module tb_uart_autobaud_detect;
  import uart_pkg::*;

  localparam int unsigned CNT_W_TB = 12;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  start;
  logic                  rx;
  logic                  o_busy, o_locked, o_det_err;
  logic [BAUD_VAL_W-1:0] o_baud_val;
  logic [FRAC_BITS-1:0]  o_baud_val_fraction;

  typedef struct packed {
    logic                  is_err;
    logic [BAUD_VAL_W-1:0] bv;
    logic [FRAC_BITS-1:0]  frac;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   model_bv = 0;    // divisor the DUT should be holding
  int   model_frac = 0;

  always #5 clk = ~clk;

  uart_autobaud_detect #(.TOL_SHIFT(3), .CNT_W(CNT_W_TB)) dut (
    .i_clk              (clk),
    .i_reset            (reset),
    .i_start            (start),
    .i_rx               (rx),
    .o_busy             (o_busy),
    .o_locked           (o_locked),
    .o_det_err          (o_det_err),
    .o_baud_val         (o_baud_val),
    .o_baud_val_fraction(o_baud_val_fraction)
  );

  // ---------------- stimulus helpers ----------------
  task automatic push_exp(input bit is_err, input int bv, input int frac);
    exp_t e;
    if (!is_err) begin
      model_bv   = bv;
      model_frac = frac;
    end
    e.is_err = is_err;
    e.bv     = BAUD_VAL_W'(model_bv);
    e.frac   = FRAC_BITS'(model_frac);
    sb_q.push_back(e);
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  // Frame = start bit, 8 data bits LSB first, stop bit. With jitter each
  // bit boundary after the first moves by -1..+1 clock.
  task automatic send_frame(input logic [7:0] data, input int period,
                            input bit jitter, input int n_bits);
    logic [9:0] bits;
    int prev_j, j, d;
    bits   = {1'b1, data, 1'b0};
    prev_j = 0;
    for (int k = 0; k < n_bits; k++) begin
      rx = bits[k];
      j  = (jitter && k < 9) ? int'($urandom_range(2)) - 1 : 0;
      d  = period + j - prev_j;
      prev_j = j;
      repeat (d) @(negedge clk);
    end
  endtask

  // Scoreboard consumer: waits for LOCKED or DET_ERR and compares.
  task automatic wait_result(input string name, input int budget);
    exp_t ex;
    bit   got;
    int   cyc;
    got = 1'b0;
    cyc = 0;
    while (!got && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (o_locked === 1'b1 || o_det_err === 1'b1) got = 1'b1;
    end
    n_checks++;
    if (sb_q.size() == 0) begin
      n_errors++;
      $display("FAIL %s: result with empty scoreboard", name);
      return;
    end
    ex = sb_q.pop_front();
    if (!got) begin
      n_errors++;
      $display("FAIL %s: no LOCKED/DET_ERR within %0d cycles", name, budget);
      return;
    end
    n_checks++;
    if (o_det_err !== ex.is_err) begin
      n_errors++;
      $display("FAIL %s outcome: det_err=%0b locked=%0b, want det_err=%0b",
               name, o_det_err, o_locked, ex.is_err);
    end
    n_checks++;
    if (o_baud_val !== ex.bv || o_baud_val_fraction !== ex.frac) begin
      n_errors++;
      $display("FAIL %s value: got %0d/%0d want %0d/%0d", name,
               o_baud_val, o_baud_val_fraction, ex.bv, ex.frac);
    end
    n_checks++;
    if (o_busy !== 1'b0 || o_locked !== !ex.is_err) begin
      n_errors++;
      $display("FAIL %s flags: busy=%0b locked=%0b want busy=0 locked=%0b",
               name, o_busy, o_locked, !ex.is_err);
    end
    if (ex.is_err) begin
      @(negedge clk);
      n_checks++;
      if (o_det_err !== 1'b0 || o_locked !== 1'b0) begin
        n_errors++;
        $display("FAIL %s pulse: det_err=%0b locked=%0b one clock later, want 0/0",
                 name, o_det_err, o_locked);
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    rx    = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({o_busy, o_locked, o_det_err} !== 3'b000) begin
      n_errors++;
      $display("FAIL reset flags: busy/locked/det_err=%b want 000",
               {o_busy, o_locked, o_det_err});
    end
    n_checks++;
    if (o_baud_val !== '0 || o_baud_val_fraction !== '0) begin
      n_errors++;
      $display("FAIL reset value: got %0d/%0d want 0/0", o_baud_val, o_baud_val_fraction);
    end
  endtask

  task automatic test_lock_160();
    push_exp(1'b0, 9, 0);
    pulse_start();
    n_checks++;
    if (o_busy !== 1'b1) begin
      n_errors++;
      $display("FAIL start_busy: busy=%0b want 1", o_busy);
    end
    fork
      send_frame(8'h55, 160, 1'b0, 10);
      wait_result("lock160", 160 * 12);
    join
  endtask

  // Includes a START while busy, which must not disturb the measurement.
  task automatic test_generator_164();
    int gen_period;
    push_exp(1'b0, 9, 2);
    pulse_start();
    fork
      send_frame(8'h55, 164, 1'b0, 10);
      wait_result("lock164", 164 * 12);
      begin
        repeat (164 * 3) @(negedge clk);
        pulse_start();
      end
    join
    // Generator bit period: 16 ticks of (BAUD_VAL+1 + FRACTION/8) clocks.
    gen_period = 16 * (int'(o_baud_val) + 1) + 2 * int'(o_baud_val_fraction);
    n_checks++;
    if (gen_period !== 164) begin
      n_errors++;
      $display("FAIL gen164: generator bit period %0d clk want 164", gen_period);
    end
  endtask

  task automatic test_bad_char();
    pulse_start();
    n_checks++;
    if (o_locked !== 1'b0 || o_busy !== 1'b1) begin
      n_errors++;
      $display("FAIL rearm: locked=%0b busy=%0b want 0/1", o_locked, o_busy);
    end
    push_exp(1'b1, 0, 0);
    fork
      send_frame(8'h57, 160, 1'b0, 10);
      wait_result("bad_0x57", 160 * 12);
    join
  endtask

  task automatic test_timeout_and_fast();
    // Line stuck low after the first edge.
    pulse_start();
    push_exp(1'b1, 0, 0);
    rx = 1'b0;
    wait_result("stuck_low", 6000);
    rx = 1'b1;
    repeat (5) @(negedge clk);
    // Single low pulse, then line stuck high.
    pulse_start();
    push_exp(1'b1, 0, 0);
    rx = 1'b0;
    repeat (20) @(negedge clk);
    rx = 1'b1;
    wait_result("stuck_high", 6000);
    repeat (5) @(negedge clk);
    // 14 clk/bit is faster than the generator can express (E < 0).
    pulse_start();
    push_exp(1'b1, 0, 0);
    fork
      send_frame(8'h55, 14, 1'b0, 10);
      wait_result("too_fast", 14 * 12);
    join
    repeat (5) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    pulse_start();
    send_frame(8'h55, 160, 1'b0, 4);
    rx = 1'b0;                      // edge 3
    repeat (20) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({o_busy, o_locked, o_det_err} !== 3'b000 ||
        o_baud_val !== '0 || o_baud_val_fraction !== '0) begin
      n_errors++;
      $display("FAIL reset_mid: busy/locked/err=%b val=%0d/%0d want 000 0/0",
               {o_busy, o_locked, o_det_err}, o_baud_val, o_baud_val_fraction);
    end
    model_bv   = 0;
    model_frac = 0;
    rx    = 1'b1;
    reset = 1'b0;
    repeat (5) @(negedge clk);
    push_exp(1'b0, 9, 0);
    pulse_start();
    fork
      send_frame(8'h55, 160, 1'b0, 10);
      wait_result("relock", 160 * 12);
    join
  endtask

  task automatic test_sweep_jitter();
    int bv_list[3];
    int period;
    bv_list = '{0, 5, 12};
    foreach (bv_list[b]) begin
      for (int fr = 0; fr < 8; fr++) begin
        period = 16 * (bv_list[b] + 1) + 2 * fr;
        push_exp(1'b0, bv_list[b], fr);
        pulse_start();
        fork
          send_frame(8'h55, period, 1'b1, 10);
          wait_result($sformatf("sweep_bv%0d_f%0d", bv_list[b], fr), period * 12);
        join
        repeat (3) @(negedge clk);
      end
    end
  endtask

  // Safety net against a hung run.
  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_lock_160();
    test_generator_164();
    test_bad_char();
    test_timeout_and_fast();
    test_reset_mid();
    test_sweep_jitter();
    n_checks++;
    if (sb_q.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard: %0d expected results never produced", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_uart_autobaud_detect
